// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty instruction fetch path.
package bitty_pkg;

    localparam int INST_W          = 16;
    localparam int DONE_BLANK_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: one write port, one registered read port with read enable.
// A same-cycle write to the address being read is forwarded (write-first).
module prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/bitty_fetch_unit.sv
// Self-sequencing instruction fetch loop for the Bitty core: issues one instruction
// from local program memory and advances on each accepted done pulse.
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 2 ** ADDR_W,
    parameter int DONE_BLANK = DONE_BLANK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              finished,
    output logic              load_err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = (DONE_BLANK < 1) ? 1 : $clog2(DONE_BLANK + 1);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [INST_W-1:0] inst_reg, inst_next;
    logic              valid_reg, valid_next;
    logic              finished_reg, finished_next;
    logic              load_err_reg, load_err_next;

    logic              busy_state;
    logic [LEN_W-1:0]  start_len;
    logic              mem_we;
    logic              mem_re;
    logic [INST_W-1:0] mem_rdata;

    assign busy_state = (state_reg == FETCH) || (state_reg == WAIT);
    assign start_len  = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    assign mem_we     = load_en && !busy_state;

    // The read is launched on the edge that enters FETCH (addressed by pc_next),
    // so the data is ready to be registered into instruction as FETCH ends.
    prog_mem #(
        .DATA_W (INST_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (mem_re),
        .raddr (pc_next),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        inst_next     = inst_reg;
        valid_next    = valid_reg;
        finished_next = finished_reg;
        load_err_next = load_en && busy_state;
        mem_re        = 1'b0;

        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    pc_next  = '0;
                    len_next = start_len;
                    if (start_len == '0) begin
                        state_next    = HALT;
                        finished_next = 1'b1;
                    end else begin
                        state_next    = FETCH;
                        finished_next = 1'b0;
                        mem_re        = 1'b1;
                    end
                end
            end
            FETCH: begin
                inst_next  = mem_rdata;
                valid_next = 1'b1;
                cnt_next   = CNT_W'(DONE_BLANK);
                state_next = WAIT;
            end
            WAIT: begin
                // A done arriving during the blanking window belongs to the
                // previous instruction or the core's own latch cycle.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (done) begin
                    valid_next = 1'b0;
                    if ({1'b0, pc_reg} == len_reg - LEN_W'(1)) begin
                        state_next    = HALT;
                        finished_next = 1'b1;
                    end else begin
                        pc_next    = pc_reg + ADDR_W'(1);
                        state_next = FETCH;
                        mem_re     = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            len_reg      <= '0;
            cnt_reg      <= '0;
            inst_reg     <= '0;
            valid_reg    <= 1'b0;
            finished_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            inst_reg     <= inst_next;
            valid_reg    <= valid_next;
            finished_reg <= finished_next;
            load_err_reg <= load_err_next;
        end
    end

    assign instruction = inst_reg;
    assign inst_valid  = valid_reg;
    assign pc          = pc_reg;
    assign busy        = busy_state;
    assign finished    = finished_reg;
    assign load_err    = load_err_reg;

endmodule
